// File: rtl/stream_arb2.sv
// stream_arb2: two-input round-robin stream arbiter with packet locking.
// Output is a single register stage. o_sel names the source input and
// drives the select of the downstream two-way mux.
module stream_arb2 #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid_0,
    input  logic [WIDTH-1:0] i_data_0,
    input  logic             i_last_0,
    output logic             o_ready_0,
    input  logic             i_valid_1,
    input  logic [WIDTH-1:0] i_data_1,
    input  logic             i_last_1,
    output logic             o_ready_1,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_last,
    output logic             o_sel,
    input  logic             i_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_0 = 2'd1,
        LOCK_1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             ptr_q, ptr_d;       // input that wins the next tie
    logic             o_valid_q, o_valid_d;
    logic [WIDTH-1:0] o_data_q, o_data_d;
    logic             o_last_q, o_last_d;
    logic             o_sel_q, o_sel_d;

    logic             grant;
    logic             load_en;
    logic             g_valid;
    logic             g_last;
    logic [WIDTH-1:0] g_data;
    logic             xfer;

    // Grant selection: locked input wins outright, otherwise single
    // requester wins, otherwise the pointer decides (also with no requests).
    always_comb begin
        grant = ptr_q;
        unique case (state_q)
            LOCK_0: grant = 1'b0;
            LOCK_1: grant = 1'b1;
            default: begin
                if (i_valid_0 && !i_valid_1)
                    grant = 1'b0;
                else if (i_valid_1 && !i_valid_0)
                    grant = 1'b1;
                else
                    grant = ptr_q;
            end
        endcase
    end

    // The output register can take a new beat when empty or draining.
    assign load_en   = !o_valid_q || i_ready;
    assign o_ready_0 = load_en && (grant == 1'b0);
    assign o_ready_1 = load_en && (grant == 1'b1);

    assign g_valid = grant ? i_valid_1 : i_valid_0;
    assign g_last  = grant ? i_last_1  : i_last_0;
    assign g_data  = grant ? i_data_1  : i_data_0;
    assign xfer    = load_en && g_valid;

    // Arbiter next state: only a granted transfer moves the FSM or pointer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            if (g_last) begin
                state_d = IDLE;
                ptr_d   = !grant;
            end else begin
                state_d = grant ? LOCK_1 : LOCK_0;
            end
        end
    end

    // Output register next value: load on transfer, drop valid on an empty
    // load slot, hold everything while stalled.
    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_last_d  = o_last_q;
        o_sel_d   = o_sel_q;
        if (load_en) begin
            o_valid_d = xfer;
            if (xfer) begin
                o_data_d = g_data;
                o_last_d = g_last;
                o_sel_d  = grant;
            end
        end
    end

    // State and output flops; reset drops any held beat.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_last_q  <= 1'b0;
            o_sel_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_last_q  <= o_last_d;
            o_sel_q   <= o_sel_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_last  = o_last_q;
    assign o_sel   = o_sel_q;

endmodule

// File: tb/tb_stream_arb2.sv
// tb_stream_arb2: vector table, directed corner sequences and a randomized
// run against a packet-level reference model of the arbiter.
module tb_stream_arb2;

    localparam int W = 16;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_valid_0 = 1'b0, i_last_0 = 1'b0;
    logic [W-1:0] i_data_0 = '0;
    logic         o_ready_0;
    logic         i_valid_1 = 1'b0, i_last_1 = 1'b0;
    logic [W-1:0] i_data_1 = '0;
    logic         o_ready_1;
    logic         o_valid, o_last, o_sel;
    logic [W-1:0] o_data;
    logic         i_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    stream_arb2 #(.WIDTH(W)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_valid_0(i_valid_0), .i_data_0(i_data_0), .i_last_0(i_last_0), .o_ready_0(o_ready_0),
        .i_valid_1(i_valid_1), .i_data_1(i_data_1), .i_last_1(i_last_1), .o_ready_1(o_ready_1),
        .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .o_sel(o_sel),
        .i_ready(i_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic         v0;
        logic [W-1:0] d0;
        logic         l0;
        logic         v1;
        logic [W-1:0] d1;
        logic         l1;
        logic         ir;
        logic         r0, r1;
        logic         ov;
        logic [W-1:0] od;
        logic         ol, os;
    } vec_t;

    vec_t vecs[13];

    task automatic drive(input logic v0, input logic [W-1:0] d0, input logic l0,
                         input logic v1, input logic [W-1:0] d1, input logic l1,
                         input logic ir);
        i_valid_0 = v0; i_data_0 = d0; i_last_0 = l0;
        i_valid_1 = v1; i_data_1 = d1; i_last_1 = l1;
        i_ready   = ir;
    endtask

    // Reference model: owner = locked input or -1, turn = tie winner.
    int           m_owner, m_turn;
    logic         m_ov, m_ol, m_os;
    logic [W-1:0] m_od;

    task automatic model_reset();
        m_owner = -1; m_turn = 0;
        m_ov = 0; m_od = '0; m_ol = 0; m_os = 0;
    endtask

    function automatic int model_grant();
        if (m_owner >= 0) return m_owner;
        if (i_valid_0 && !i_valid_1) return 0;
        if (i_valid_1 && !i_valid_0) return 1;
        return m_turn;
    endfunction

    initial begin
        // {v0,d0,l0, v1,d1,l1, ir, r0,r1, ov,od,ol,os}
        vecs[0]  = '{1, 16'h1234, 1, 0, 16'h0000, 0, 1, 1, 0, 1, 16'h1234, 1, 0};
        vecs[1]  = '{1, 16'hA000, 1, 1, 16'hB000, 1, 1, 0, 1, 1, 16'hB000, 1, 1};
        vecs[2]  = '{1, 16'hA000, 1, 1, 16'hB001, 1, 1, 1, 0, 1, 16'hA000, 1, 0};
        vecs[3]  = '{1, 16'hA001, 1, 1, 16'hB001, 1, 1, 0, 1, 1, 16'hB001, 1, 1};
        vecs[4]  = '{0, 16'h0000, 0, 1, 16'hC000, 0, 1, 0, 1, 1, 16'hC000, 0, 1};
        vecs[5]  = '{1, 16'hA010, 1, 1, 16'hC001, 0, 1, 0, 1, 1, 16'hC001, 0, 1};
        vecs[6]  = '{1, 16'hA010, 1, 0, 16'h0000, 0, 1, 0, 1, 0, 16'hC001, 0, 1};
        vecs[7]  = '{1, 16'hA010, 1, 1, 16'hC002, 1, 1, 0, 1, 1, 16'hC002, 1, 1};
        vecs[8]  = '{1, 16'hA010, 1, 1, 16'hD000, 1, 0, 0, 0, 1, 16'hC002, 1, 1};
        vecs[9]  = '{1, 16'hA010, 1, 1, 16'hD000, 1, 0, 0, 0, 1, 16'hC002, 1, 1};
        vecs[10] = '{1, 16'hA010, 1, 1, 16'hD000, 1, 1, 1, 0, 1, 16'hA010, 1, 0};
        vecs[11] = '{0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 1, 0, 16'hA010, 1, 0};
        vecs[12] = '{0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 16'hA010, 1, 0};

        // Reset state
        #2;
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_last", o_last, 0);
        chk("rst_sel", o_sel, 0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Vector table: ready checked before the edge, outputs after it
        for (int i = 0; i < 13; i++) begin
            @(negedge i_clk);
            drive(vecs[i].v0, vecs[i].d0, vecs[i].l0, vecs[i].v1, vecs[i].d1, vecs[i].l1, vecs[i].ir);
            #1;
            chk($sformatf("v%0d_r0", i), o_ready_0, vecs[i].r0);
            chk($sformatf("v%0d_r1", i), o_ready_1, vecs[i].r1);
            @(posedge i_clk); #1;
            chk($sformatf("v%0d_ov", i), o_valid, vecs[i].ov);
            chk($sformatf("v%0d_od", i), o_data, vecs[i].od);
            chk($sformatf("v%0d_ol", i), o_last, vecs[i].ol);
            chk($sformatf("v%0d_os", i), o_sel, vecs[i].os);
        end

        // Locked input 0 with a gap: input 1 must stay blocked
        @(negedge i_clk);
        drive(1, 16'h0E00, 0, 1, 16'h0F00, 1, 1);  // tie, turn is input 1
        @(posedge i_clk); #1;
        chk("gap_first_sel", o_sel, 1);
        @(negedge i_clk);
        drive(1, 16'h0E00, 0, 0, 16'h0000, 0, 1);  // input 0 starts packet
        @(posedge i_clk); #1;
        chk("gap_start_sel", o_sel, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            drive(0, 16'h0000, 0, 1, 16'h0F01, 1, 1);
            #1;
            chk("gap_r1_blocked", o_ready_1, 0);
            @(posedge i_clk); #1;
            chk("gap_no_out", o_valid, 0);
        end
        @(negedge i_clk);
        drive(1, 16'h0E01, 1, 1, 16'h0F01, 1, 1);
        #1;
        chk("gap_end_r0", o_ready_0, 1);
        @(posedge i_clk); #1;
        chk("gap_end_data", o_data, 16'h0E01);
        @(negedge i_clk);
        #1;
        chk("gap_next_r1", o_ready_1, 1);

        // Asynchronous reset mid-packet while the output holds a beat
        drive(1, 16'h5555, 0, 0, 16'h0000, 0, 1);
        @(posedge i_clk); #1;
        chk("mid_valid_before", o_valid, 1);
        #1 i_rst = 1'b1;
        #1;
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_data", o_data, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        drive(1, 16'h6000, 1, 1, 16'h7000, 1, 1);
        #1;
        chk("post_rst_tie_r0", o_ready_0, 1);
        chk("post_rst_tie_r1", o_ready_1, 0);
        @(posedge i_clk); #1;
        chk("post_rst_data", o_data, 16'h6000);

        // Randomized run against the model, from a fresh reset
        @(negedge i_clk);
        i_rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1 i_rst = 1'b0;
        model_reset();
        for (int c = 0; c < 600; c++) begin
            int  g;
            logic acc;
            logic [W-1:0] gd;
            logic gl, gv;
            @(negedge i_clk);
            drive($urandom_range(9) < 7, W'($urandom), $urandom_range(2) == 0,
                  $urandom_range(9) < 7, W'($urandom), $urandom_range(2) == 0,
                  $urandom_range(3) != 0);
            #1;
            g   = model_grant();
            acc = !m_ov || i_ready;
            chk("rnd_r0", o_ready_0, acc && g == 0);
            chk("rnd_r1", o_ready_1, acc && g == 1);
            gv = (g == 0) ? i_valid_0 : i_valid_1;
            gd = (g == 0) ? i_data_0  : i_data_1;
            gl = (g == 0) ? i_last_0  : i_last_1;
            if (acc) begin
                m_ov = gv;
                if (gv) begin
                    m_od = gd; m_ol = gl; m_os = (g == 1);
                    if (gl) begin
                        m_owner = -1;
                        m_turn  = 1 - g;
                    end else begin
                        m_owner = g;
                    end
                end
            end
            @(posedge i_clk); #1;
            chk("rnd_ov", o_valid, m_ov);
            chk("rnd_od", o_data, m_od);
            chk("rnd_ol", o_last, m_ol);
            chk("rnd_os", o_sel, m_os);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
